// File: rtl/am2901_core_if.sv
// Am2901 slice bus: microinstruction, operands, shift lines, status.
// master drives instructions and operands; slave is the core.
interface am2901_core_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  logic [8:0]        i;
  logic              instr_valid;
  logic [ADDR_W-1:0] a;
  logic [ADDR_W-1:0] b;
  logic [WIDTH-1:0]  d;
  logic              cin;
  logic              use_cflag;
  logic              ram_lsb_in;
  logic              ram_msb_in;
  logic              q_lsb_in;
  logic              q_msb_in;
  logic              oe;
  logic [WIDTH-1:0]  y;
  logic              y_en;
  logic              ram_lsb_out;
  logic              ram_msb_out;
  logic              q_lsb_out;
  logic              q_msb_out;
  logic              cout;
  logic              ovr;
  logic              zero;
  logic              neg;
  logic              g_n;
  logic              p_n;
  logic              cflag;
  logic              zflag;

  modport master (
    output i, instr_valid, a, b, d, cin, use_cflag,
    output ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in, oe,
    input  y, y_en, ram_lsb_out, ram_msb_out,
    input  q_lsb_out, q_msb_out,
    input  cout, ovr, zero, neg, g_n, p_n, cflag, zflag
  );

  modport slave (
    input  i, instr_valid, a, b, d, cin, use_cflag,
    input  ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in, oe,
    output y, y_en, ram_lsb_out, ram_msb_out,
    output q_lsb_out, q_msb_out,
    output cout, ovr, zero, neg, g_n, p_n, cflag, zflag
  );
endinterface

// File: rtl/am2901_core.sv
// Am2901-style bit-slice ALU: register file, Q register, ALU, shifter.
// Ports: clk, rst (async high), bus (am2901_core_if.slave).
module am2901_core #(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 16,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input logic clk,
  input logic rst,
  am2901_core_if.slave bus
);
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] q;
  logic             cflag_r;
  logic             zflag_r;

  logic [2:0] src, func, dest;
  assign src  = bus.i[2:0];
  assign func = bus.i[5:3];
  assign dest = bus.i[8:6];

  logic [WIDTH-1:0] a_q, b_q;
  assign a_q = regs[bus.a];
  assign b_q = regs[bus.b];

  logic [WIDTH-1:0] r, s;
  always_comb begin
    r = '0;
    s = '0;
    unique case (src)
      3'd0: begin r = a_q;   s = q;   end
      3'd1: begin r = a_q;   s = b_q; end
      3'd2: begin r = '0;    s = q;   end
      3'd3: begin r = '0;    s = b_q; end
      3'd4: begin r = '0;    s = a_q; end
      3'd5: begin r = bus.d; s = a_q; end
      3'd6: begin r = bus.d; s = q;   end
      default: begin r = bus.d; s = '0; end
    endcase
  end

  logic ci;
  assign ci = bus.use_cflag ? cflag_r : bus.cin;

  // Subtract variants invert one operand ahead of a shared adder.
  logic [WIDTH-1:0] op_r, op_s;
  assign op_r = (func == 3'd1) ? ~r : r;
  assign op_s = (func == 3'd2) ? ~s : s;

  logic [WIDTH:0] sum;
  assign sum = {1'b0, op_r} + {1'b0, op_s}
             + {{WIDTH{1'b0}}, ci};

  logic arith;
  assign arith = (func == 3'd0) || (func == 3'd1)
              || (func == 3'd2);

  logic [WIDTH-1:0] f;
  always_comb begin
    f = '0;
    unique case (func)
      3'd0, 3'd1, 3'd2: f = sum[WIDTH-1:0];
      3'd3: f = r | s;
      3'd4: f = r & s;
      3'd5: f = ~r & s;
      3'd6: f = r ^ s;
      default: f = ~(r ^ s);
    endcase
  end

  // Carry into the MSB recovered from the MSB sum bit.
  logic c_msb;
  assign c_msb = op_r[WIDTH-1] ^ op_s[WIDTH-1]
               ^ sum[WIDTH-1];

  logic cout_w, zero_w;
  assign cout_w = arith & sum[WIDTH];
  assign zero_w = (f == '0);

  assign bus.cout = cout_w;
  assign bus.ovr  = arith & (c_msb ^ sum[WIDTH]);
  assign bus.zero = zero_w;
  assign bus.neg  = f[WIDTH-1];
  assign bus.p_n  = ~&(r | s);
  assign bus.g_n  = ~cout_w;

  assign bus.y     = (dest == 3'd2) ? a_q : f;
  assign bus.y_en  = bus.oe;
  assign bus.cflag = cflag_r;
  assign bus.zflag = zflag_r;

  assign bus.ram_lsb_out = f[0];
  assign bus.ram_msb_out = f[WIDTH-1];
  assign bus.q_lsb_out   = q[0];
  assign bus.q_msb_out   = q[WIDTH-1];

  logic             wr_b, wr_q;
  logic [WIDTH-1:0] b_nxt, q_nxt;
  always_comb begin
    wr_b  = 1'b0;
    wr_q  = 1'b0;
    b_nxt = f;
    q_nxt = f;
    unique case (dest)
      3'd0: wr_q = 1'b1;
      3'd1: ;
      3'd2, 3'd3: wr_b = 1'b1;
      3'd4, 3'd5: begin
        wr_b  = 1'b1;
        wr_q  = (dest == 3'd4);
        b_nxt = {bus.ram_msb_in, f[WIDTH-1:1]};
        q_nxt = {bus.q_msb_in, q[WIDTH-1:1]};
      end
      default: begin
        wr_b  = 1'b1;
        wr_q  = (dest == 3'd6);
        b_nxt = {f[WIDTH-2:0], bus.ram_lsb_in};
        q_nxt = {q[WIDTH-2:0], bus.q_lsb_in};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      q       <= '0;
      cflag_r <= 1'b0;
      zflag_r <= 1'b0;
    end else if (bus.instr_valid) begin
      if (wr_b) regs[bus.b] <= b_nxt;
      if (wr_q) q <= q_nxt;
      cflag_r <= cout_w;
      zflag_r <= zero_w;
    end
  end
endmodule

// File: tb/tb_am2901_core.sv
// Directed bench for am2901_core at 8-bit/16-reg and 16-bit/32-reg.
// Expected values are hand computed per vector.
module tb_am2901_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  am2901_core_if #(.WIDTH(8),  .ADDR_W(4)) bus8  ();
  am2901_core_if #(.WIDTH(16), .ADDR_W(5)) bus16 ();

  am2901_core #(.WIDTH(8), .NREGS(16)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8.slave)
  );
  am2901_core #(.WIDTH(16), .NREGS(32)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [8:0] ii,
                     input logic [3:0] aa, bb,
                     input logic [7:0] dd,
                     input logic v);
    bus8.i = ii; bus8.a = aa; bus8.b = bb;
    bus8.d = dd; bus8.instr_valid = v;
    #1;
  endtask

  task automatic rd8(input logic [3:0] aa,
                     input logic [7:0] exp,
                     input string tag);
    bus8.use_cflag = 1'b0;
    bus8.cin = 1'b0;
    op8(9'o104, aa, 4'd0, 8'h00, 1'b0);
    chk(tag, 32'(bus8.y), 32'(exp));
  endtask

  task automatic op16(input logic [8:0] ii,
                      input logic [4:0] aa, bb,
                      input logic [15:0] dd,
                      input logic v);
    bus16.i = ii; bus16.a = aa; bus16.b = bb;
    bus16.d = dd; bus16.instr_valid = v;
    #1;
  endtask

  task automatic rd16(input logic [4:0] aa,
                      input logic [15:0] exp,
                      input string tag);
    bus16.use_cflag = 1'b0;
    bus16.cin = 1'b0;
    op16(9'o104, aa, 5'd0, 16'h0, 1'b0);
    chk(tag, 32'(bus16.y), 32'(exp));
  endtask

  initial begin
    bus8.cin = 0; bus8.use_cflag = 0; bus8.oe = 1;
    bus8.ram_lsb_in = 0; bus8.ram_msb_in = 0;
    bus8.q_lsb_in = 0; bus8.q_msb_in = 0;
    bus16.cin = 0; bus16.use_cflag = 0; bus16.oe = 1;
    bus16.ram_lsb_in = 0; bus16.ram_msb_in = 0;
    bus16.q_lsb_in = 0; bus16.q_msb_in = 0;
    op8(9'o104, 0, 0, 0, 0);
    op16(9'o104, 0, 0, 0, 0);

    // Reset state
    rd8(4'd3, 8'h00, "rst_reg3");
    rd8(4'd15, 8'h00, "rst_reg15");
    chk("rst_cflag", 32'(bus8.cflag), 0);
    chk("rst_zflag", 32'(bus8.zflag), 0);
    chk("y_en_hi", 32'(bus8.y_en), 1);
    bus8.oe = 0; #1;
    chk("y_en_lo", 32'(bus8.y_en), 0);
    bus8.oe = 1;
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Load D into reg3, readable next cycle
    op8(9'o307, 4'd0, 4'd3, 8'h5A, 1'b1);
    chk("ld_y", 32'(bus8.y), 32'h5A);
    tick();
    rd8(4'd3, 8'h5A, "ld_rd3");

    op8(9'o307, 4'd0, 4'd1, 8'hFF, 1'b1); tick();
    op8(9'o307, 4'd0, 4'd2, 8'h01, 1'b1); tick();

    // FF + 01 -> 00 with carry
    op8(9'o301, 4'd1, 4'd2, 8'h00, 1'b1);
    chk("add_y", 32'(bus8.y), 0);
    chk("add_cout", 32'(bus8.cout), 1);
    chk("add_zero", 32'(bus8.zero), 1);
    chk("add_ovr", 32'(bus8.ovr), 0);
    chk("add_gn", 32'(bus8.g_n), 0);
    tick();
    chk("add_cflag", 32'(bus8.cflag), 1);
    chk("add_zflag", 32'(bus8.zflag), 1);
    rd8(4'd2, 8'h00, "add_rd2");

    // Chained add consumes cflag, cin ignored
    bus8.use_cflag = 1; bus8.cin = 0;
    op8(9'o101, 4'd0, 4'd0, 8'h00, 1'b1);
    chk("mw_y", 32'(bus8.y), 1);
    tick();
    chk("mw_cflag", 32'(bus8.cflag), 0);
    chk("mw_zflag", 32'(bus8.zflag), 0);
    bus8.use_cflag = 0;

    // Q=81, right shift
    op8(9'o007, 4'd0, 4'd0, 8'h81, 1'b1); tick();
    bus8.ram_msb_in = 1; bus8.q_msb_in = 0;
    op8(9'o407, 4'd0, 4'd4, 8'h02, 1'b1);
    chk("sh_rlsb", 32'(bus8.ram_lsb_out), 0);
    chk("sh_rmsb", 32'(bus8.ram_msb_out), 0);
    chk("sh_qlsb", 32'(bus8.q_lsb_out), 1);
    chk("sh_qmsb", 32'(bus8.q_msb_out), 1);
    tick();
    bus8.ram_msb_in = 0;
    rd8(4'd4, 8'h81, "shr_b");
    op8(9'o102, 4'd0, 4'd0, 8'h00, 1'b0);
    chk("shr_q", 32'(bus8.y), 32'h40);

    // Left shift with fill ones
    bus8.ram_lsb_in = 1; bus8.q_lsb_in = 1;
    op8(9'o607, 4'd0, 4'd5, 8'h81, 1'b1); tick();
    bus8.ram_lsb_in = 0; bus8.q_lsb_in = 0;
    rd8(4'd5, 8'h03, "shl_b");
    op8(9'o102, 4'd0, 4'd0, 8'h00, 1'b0);
    chk("shl_q", 32'(bus8.y), 32'h81);

    // Dest 2 drives A on y
    op8(9'o207, 4'd3, 4'd6, 8'h11, 1'b1);
    chk("d2_y", 32'(bus8.y), 32'h5A);
    tick();
    rd8(4'd6, 8'h11, "d2_rd6");

    // Combinational ALU functions
    bus8.cin = 1;
    op8(9'o111, 4'd6, 4'd3, 8'h00, 1'b0);
    chk("sub_y", 32'(bus8.y), 32'h49);
    chk("sub_cout", 32'(bus8.cout), 1);
    op8(9'o125, 4'd3, 4'd0, 8'h60, 1'b0);
    chk("rsub_y", 32'(bus8.y), 32'h06);
    op8(9'o107, 4'd0, 4'd0, 8'h7F, 1'b0);
    chk("ov_y", 32'(bus8.y), 32'h80);
    chk("ov_ovr", 32'(bus8.ovr), 1);
    chk("ov_neg", 32'(bus8.neg), 1);
    chk("ov_cout", 32'(bus8.cout), 0);
    bus8.cin = 0;
    op8(9'o165, 4'd3, 4'd0, 8'hFF, 1'b0);
    chk("xor_y", 32'(bus8.y), 32'hA5);
    op8(9'o145, 4'd3, 4'd0, 8'h0F, 1'b0);
    chk("and_y", 32'(bus8.y), 32'h0A);
    chk("and_pn", 32'(bus8.p_n), 1);

    // Held instruction with instr_valid low
    op8(9'o305, 4'd1, 4'd3, 8'h01, 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk("hold_y", 32'(bus8.y), 0);
      chk("hold_cout", 32'(bus8.cout), 1);
      tick();
    end
    chk("hold_cflag", 32'(bus8.cflag), 0);
    chk("hold_zflag", 32'(bus8.zflag), 0);
    rd8(4'd3, 8'h5A, "hold_rd3");
    op8(9'o102, 4'd0, 4'd0, 8'h00, 1'b0);
    chk("hold_q", 32'(bus8.y), 32'h81);

    // a==b write: old value until the edge
    op8(9'o305, 4'd3, 4'd3, 8'h01, 1'b1);
    chk("nobyp_pre", 32'(bus8.y), 32'h5B);
    tick();
    chk("nobyp_post", 32'(bus8.y), 32'h5C);

    // Mid-cycle reset loses pending write
    op8(9'o307, 4'd0, 4'd8, 8'h33, 1'b1); tick();
    op8(9'o305, 4'd8, 4'd9, 8'h00, 1'b1);
    chk("mr_pre", 32'(bus8.y), 32'h33);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_rd8", 32'(bus8.y), 0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    rd8(4'd9, 8'h00, "mr_rd9");
    rd8(4'd3, 8'h00, "mr_rd3");
    op8(9'o307, 4'd0, 4'd9, 8'h66, 1'b1); tick();
    rd8(4'd9, 8'h66, "post_rst_wr");

    // Wide configuration
    op16(9'o307, 5'd0, 5'd3, 16'h5A5A, 1'b1); tick();
    rd16(5'd3, 16'h5A5A, "w_rd3");
    op16(9'o307, 5'd0, 5'd1, 16'hFFFF, 1'b1); tick();
    op16(9'o307, 5'd0, 5'd2, 16'h0001, 1'b1); tick();
    op16(9'o301, 5'd1, 5'd2, 16'h0, 1'b1);
    chk("w_add_y", 32'(bus16.y), 0);
    chk("w_add_cout", 32'(bus16.cout), 1);
    chk("w_add_zero", 32'(bus16.zero), 1);
    chk("w_add_ovr", 32'(bus16.ovr), 0);
    tick();
    chk("w_cflag", 32'(bus16.cflag), 1);
    rd16(5'd2, 16'h0, "w_rd2");
    bus16.use_cflag = 1;
    op16(9'o101, 5'd0, 5'd0, 16'h0, 1'b0);
    chk("w_mw_y", 32'(bus16.y), 1);
    bus16.use_cflag = 0;
    op16(9'o307, 5'd0, 5'd31, 16'h1234, 1'b1); tick();
    rd16(5'd31, 16'h1234, "w_rd31");
    op16(9'o107, 5'd0, 5'd0, 16'h00FF, 1'b0);
    chk("w_no8carry", 32'(bus16.y), 32'h00FF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=%0d exp=%0d", n_total, 0);
    $fatal(1);
  end
endmodule

// File: doc/am2901_core.md
AM2901_CORE -- requirements
Module: am2901_core

Interface
REQ-001 Parameter WIDTH, default 8: datapath width in bits; legal values 4 to 32.
REQ-002 Parameter NREGS, default 16: register-file depth; power of two, 2 to 64.
REQ-003 Parameter ADDR_W, default $clog2(NREGS): width of the register address ports.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 i  input  9  microinstruction: i[2:0] source, i[5:3] function, i[8:6] destination (Am2901 encoding).
REQ-007 instr_valid  input  1  when high, the current instruction commits state at the next edge.
REQ-008 a, b  input  ADDR_W each  register addresses; b is also the write address.
REQ-009 d  input  WIDTH  external data operand.
REQ-010 cin  input  1  external carry-in.
REQ-011 use_cflag  input  1  when high, the latched carry flag replaces cin (multi-word add/subtract).
REQ-012 ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in  input  1 each  serial shift-in bits.
REQ-013 y  output  WIDTH  result bus; oe  input  1; y_en  output  1, equal to oe.
REQ-014 ram_lsb_out, ram_msb_out, q_lsb_out, q_msb_out  output  1 each  shifted-out bits.
REQ-015 cout, ovr, zero, neg, g_n, p_n  output  1 each  combinational ALU status.
REQ-016 cflag, zflag  output  1 each  registered carry and zero flags.

Function
REQ-017 Source select (R,S) by i[2:0]: 0=A,Q; 1=A,B; 2=0,Q; 3=0,B; 4=0,A; 5=D,A; 6=D,Q; 7=D,0.
REQ-018 Effective carry: ci = use_cflag ? cflag : cin.
REQ-019 Function by i[5:3], computed mod 2^WIDTH: 0=R+S+ci; 1=S+~R+ci; 2=R+~S+ci; 3=R|S; 4=R&S; 5=~R&S; 6=R^S; 7=~(R^S).
REQ-020 Status: cout is the carry out of bit WIDTH-1 (0 for logic ops); ovr is the carry into the MSB XOR cout; zero = (F==0); neg = F[WIDTH-1]; p_n = ~&(R|S); g_n = ~cout.
REQ-021 Destination by i[8:6]:
- 0: Q<=F
- 1: no write
- 2: B<=F, y=A
- 3: B<=F
- 4: B<=F>>1, Q<=Q>>1
- 5: B<=F>>1
- 6: B<=F<<1, Q<=Q<<1
- 7: B<=F<<1
- y=F for every code except 2.
REQ-022 Right shift (codes 4, 5): MSB fill comes from ram_msb_in and q_msb_in.
REQ-023 Left shift (codes 6, 7): LSB fill comes from ram_lsb_in and q_lsb_in.
REQ-024 Shift-out bits ram_lsb_out=F[0], ram_msb_out=F[WIDTH-1], q_lsb_out=Q[0], q_msb_out=Q[WIDTH-1] are always driven, independent of destination code.
REQ-025 Register-file and Q writes, and the cflag/zflag updates (cflag<=cout, zflag<=zero), occur only at a rising edge with instr_valid=1.
REQ-026 With instr_valid=0, no state changes; y and the status outputs still track the inputs combinationally.
REQ-027 Reads are asynchronous and return pre-edge contents; a==b with a write returns the old value until the edge (no bypass).
REQ-028 Latency: y and status are valid in the same cycle; written results are readable in the cycle after the edge.
REQ-029 Back-to-back valid instructions are accepted every cycle without stalls.
REQ-030 With use_cflag=1, chained instructions see the cflag written by the immediately preceding valid instruction.

Reset
REQ-031 While rst=1: all NREGS registers, Q, cflag and zflag are 0, asynchronously, regardless of clk or instr_valid.
REQ-032 A write coinciding with the assertion of rst is discarded.
REQ-033 The first valid edge after rst deasserts executes normally.

Verification
REQ-034 (WIDTH=8) Reset, then i=8'o... dest 3, func 0, src 7 with d=0x5A, b=3, valid → reg3=0x5A; the next read of a=3 gives y=0x5A.
REQ-035 reg1=0xFF, reg2=0x01, src 1, func 0, cin=0, dest 3, b=2 → F=0x00, cout=1, zero=1, ovr=0; reg2=0x00, cflag=1.
REQ-036 Multi-word add with use_cflag=1 after REQ-035 (A=0, B=0, src 1, func 0) → F=0x01.
REQ-037 Q=0x81, dest 4, ram_msb_in=1, q_msb_in=0, F=0x02 → B<=0x81, Q<=0x40.
REQ-038 Valid instruction held with instr_valid=0 for 3 cycles → no register, Q or flag change; y still shows F.
REQ-039 rst asserted mid-cycle between two valid writes → all registers read 0 immediately; the pending write is lost.
REQ-040 Repeat REQ-034 and REQ-035 with WIDTH=16, NREGS=32 → identical behaviour, with carry out of bit 15.
